// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Sign-magnitude core: operands are reduced to magnitudes at start and the signs are reapplied in FIN.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             WriteHi,
    input  logic             WriteLo,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} stateType;
    stateType state, nextState;
    logic [5:0] count;
    logic isDiv, negQ, negR, startDiv, divZeroIn, divGe;
    logic [WIDTH-1:0] accHi, accLo, opB, magA, magB, divDiff, resHi, resLo;
    logic [WIDTH:0] mulSum, divShift;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        startDiv = Op[1];
        divZeroIn = Start && startDiv && OperandB == '0;
        magA = (!Op[0] && OperandA[WIDTH-1]) ? -OperandA : OperandA;
        magB = (!Op[0] && OperandB[WIDTH-1]) ? -OperandB : OperandB;
        mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
        divShift = {accHi, accLo[WIDTH-1]};
        divGe = divShift >= {1'b0, opB};
        divDiff = divShift[WIDTH-1:0] - opB;
        prod = negQ ? -{accHi, accLo} : {accHi, accLo};
        resHi = isDiv ? (negR ? -accHi : accHi) : prod[2*WIDTH-1:WIDTH];
        resLo = isDiv ? (negQ ? -accLo : accLo) : prod[WIDTH-1:0];
        nextState = state == IDLE ? (Start ? (divZeroIn ? FIN : RUN) : IDLE)
                  : state == RUN  ? (count == 6'(WIDTH) ? FIN : RUN)
                  : IDLE;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            Busy <= 1'b0;
            Done <= 1'b0;
            DivByZero <= 1'b0;
            Hi <= '0;
            Lo <= '0;
            count <= '0;
            isDiv <= 1'b0;
            negQ <= 1'b0;
            negR <= 1'b0;
            accHi <= '0;
            accLo <= '0;
            opB <= '0;
        end else begin
            state <= nextState;
            Busy <= nextState != IDLE;
            Done <= nextState == FIN;
            DivByZero <= state == IDLE && divZeroIn;
            if (state == IDLE) begin
                if (WriteHi) Hi <= WriteData;
                if (WriteLo) Lo <= WriteData;
                if (Start) begin
                    isDiv <= startDiv;
                    negQ <= !Op[0] && (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
                    negR <= !Op[0] && OperandA[WIDTH-1];
                    accHi <= '0;
                    accLo <= startDiv ? magA : magB;
                    opB <= startDiv ? magB : magA;
                    count <= '0;
                end
            end
            // multiply: shift-add into {accHi,accLo}; divide: restoring step, quotient bits shift into accLo
            if (state == RUN && count != 6'(WIDTH)) begin
                accHi <= isDiv ? (divGe ? divDiff : divShift[WIDTH-1:0]) : mulSum[WIDTH:1];
                accLo <= isDiv ? {accLo[WIDTH-2:0], divGe} : {mulSum[0], accLo[WIDTH-1:1]};
                count <= count + 6'd1;
            end
            if (state == FIN && !DivByZero) begin
                Hi <= resHi;
                Lo <= resLo;
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized + directed scoreboard bench for mult_div_unit.
// Expected HI/LO come from plain 64-bit arithmetic; a monitor checks every Done pulse against the queue.
module tb_mult_div_unit;
    logic Clock = 0, Reset = 1, Start = 0, WriteHi = 0, WriteLo = 0;
    logic [1:0] Op = 0;
    logic [31:0] OperandA = 0, OperandB = 0, WriteData = 0;
    logic Busy, Done, DivByZero;
    logic [31:0] Hi, Lo;
    int total = 0, bad = 0, cyc = 0;
    typedef struct {logic [31:0] hi; logic [31:0] lo; logic dz; int at;} expType;
    expType q[$];
    logic [31:0] mHi = 0, mLo = 0, runHi = 0, runLo = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
        .OperandA(OperandA), .OperandB(OperandB),
        .WriteHi(WriteHi), .WriteLo(WriteLo), .WriteData(WriteData),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] refOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'd0: return 64'(sa * sb);
            2'd1: return ua * ub;
            2'd2: return {32'(sa % sb), 32'(sa / sb)};
            default: return {32'(ua % ub), 32'(ua / ub)};
        endcase
    endfunction

    // drive a start at the current time (caller positions at a negedge), push the expectation
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wh, input logic wl, input logic [31:0] wd);
        expType e;
        logic [63:0] r;
        Op = op; OperandA = a; OperandB = b;
        WriteHi = wh; WriteLo = wl; WriteData = wd; Start = 1;
        @(posedge Clock);
        #1;
        Start = 0; WriteHi = 0; WriteLo = 0;
        if (wh) mHi = wd;
        if (wl) mLo = wd;
        runHi = mHi;
        runLo = mLo;
        e.dz = op[1] && b == 0;
        if (!e.dz) begin
            r = refOp(op, a, b);
            mHi = r[63:32];
            mLo = r[31:0];
        end
        e.hi = mHi;
        e.lo = mLo;
        e.at = e.dz ? cyc : cyc + 33;
        q.push_back(e);
        check("busy_after_start", Busy, 1);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (Busy && n < 100) begin
            @(negedge Clock);
            n++;
        end
        check("idle_timeout", Busy, 0);
    endtask

    initial begin : monitor
        expType e;
        forever begin
            @(negedge Clock);
            if (DivByZero && !Done) check("dz_without_done", DivByZero, 0);
            if (Done) begin
                if (q.size() == 0) check("done_unexpected", Done, 0);
                else begin
                    e = q.pop_front();
                    check("done_cycle", cyc, e.at);
                    check("done_busy", Busy, 1);
                    check("divbyzero", DivByZero, e.dz);
                    @(negedge Clock);
                    check("hi", Hi, e.hi);
                    check("lo", Lo, e.lo);
                end
            end
        end
    end

    logic [1:0]  dOp[5] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2};
    logic [31:0] dA[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000};
    logic [31:0] dB[5]  = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd7, 32'hFFFFFFFF};
    logic [31:0] dHi[5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0};
    logic [31:0] dLo[5] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'd14, 32'h80000000};

    initial begin
        #12;
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_dz", DivByZero, 0);
        check("rst_hi", Hi, 0);
        check("rst_lo", Lo, 0);
        @(negedge Clock);
        Reset = 0;
        for (int i = 0; i < 5; i++) begin
            issue(dOp[i], dA[i], dB[i], 0, 0, 0);
            waitIdle();
            check("dir_hi", Hi, dHi[i]);
            check("dir_lo", Lo, dLo[i]);
        end

        WriteHi = 1; WriteData = 32'h12345678;
        @(negedge Clock);
        WriteHi = 0;
        mHi = 32'h12345678;
        check("mthi", Hi, 32'h12345678);
        issue(2'd3, 32'd5, 32'd0, 0, 0, 0);
        waitIdle();
        check("dz_hi_kept", Hi, 32'h12345678);

        issue(2'd3, 32'd1000, 32'd7, 0, 0, 0);
        repeat (10) @(negedge Clock);
        check("run_hi_stable", Hi, runHi);
        check("run_lo_stable", Lo, runLo);
        Start = 1; Op = 2'd0; OperandA = 32'd3; OperandB = 32'd3;
        WriteLo = 1; WriteData = 32'hDEADBEEF;
        @(posedge Clock);
        #1;
        Start = 0; WriteLo = 0;
        waitIdle();
        check("ignored_lo", Lo, 32'd142);
        check("ignored_hi", Hi, 32'd6);

        @(negedge Clock);
        issue(2'd0, 32'd12345, 32'hFFFFFD2A, 0, 0, 0);
        repeat (19) @(negedge Clock);
        Reset = 1;
        #1;
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        check("abort_hi", Hi, 0);
        check("abort_lo", Lo, 0);
        q.delete();
        mHi = 0;
        mLo = 0;
        repeat (2) @(negedge Clock);
        Reset = 0;
        issue(2'd1, 32'h00010000, 32'h00010000, 0, 0, 0);
        waitIdle();
        check("post_rst_hi", Hi, 32'd1);
        check("post_rst_lo", Lo, 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b, wd;
            if ($urandom_range(0, 3) == 0) begin
                wd = $urandom;
                WriteHi = $urandom_range(0, 1);
                WriteLo = !WriteHi || $urandom_range(0, 1) == 1;
                WriteData = wd;
                if (WriteHi) mHi = wd;
                if (WriteLo) mLo = wd;
                @(negedge Clock);
                WriteHi = 0; WriteLo = 0;
                check("mt_hi", Hi, mHi);
                check("mt_lo", Lo, mLo);
            end
            a = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 300)) : $urandom;
            b = $urandom_range(0, 7) == 0 ? 32'd0 : ($urandom_range(0, 2) == 0 ? 32'($urandom_range(1, 20)) : $urandom);
            if ($urandom_range(0, 3) == 0) b = -b;
            wd = $urandom;
            issue(2'($urandom_range(0, 3)), a, b, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, wd);
            waitIdle();
        end

        repeat (5) @(negedge Clock);
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width; only 32 is required to be supported.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: Clock (input, 1, all state updates on posedge Clock) and Reset (input, 1, async active-high clear).
REQ-003 SHALL have port Start, input, 1: request an operation; sampled on posedge Clock.
REQ-004 SHALL have port Op, input, 2: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port OperandA, input, 32: rs value from register file ReadDataOne; multiplicand or dividend.
REQ-006 SHALL have port OperandB, input, 32: rt value from register file ReadDataTwo; multiplier or divisor.
REQ-007 SHALL have ports WriteHi and WriteLo, input, 1 each: MTHI / MTLO strobes.
REQ-008 SHALL have port WriteData, input, 32: MTHI / MTLO data.
REQ-009 SHALL have port Busy, output, 1: operation in progress.
REQ-010 SHALL have port Done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port DivByZero, output, 1: pulses with Done when the divisor was 0.
REQ-012 SHALL have ports Hi and Lo, output, 32 each: architectural HI/LO, read by MFHI / MFLO toward the register-file write port.

Function
REQ-013 SHALL implement three states: IDLE, RUN, FIN.
REQ-014 SHALL, when in IDLE with Start=1, latch Op, operand magnitudes (signed ops) or raw values (unsigned ops) and result signs, clear a 6-bit counter, and enter RUN; Start SHALL be ignored in RUN and FIN.
REQ-015 SHALL, in RUN, process one bit per cycle: shift-add for multiply, restoring shift-subtract for divide; after 32 RUN cycles SHALL enter FIN.
REQ-016 SHALL, in FIN, apply sign correction and load Hi and Lo on the FIN-to-IDLE edge, assert Done=1 for that FIN cycle, and return to IDLE.
REQ-017 SHALL time its outputs as follows: with Start accepted at edge N, Done is high between edges N+33 and N+34, and Hi/Lo are updated at edge N+34.
REQ-018 SHALL assert Busy=1 exactly in RUN and FIN; Busy SHALL be a registered state decode.
REQ-019 SHALL produce, for MULT/MULTU, the 64-bit product with {Hi,Lo} = product and Hi = upper 32 bits; for MULT, the product SHALL be a two's-complement signed product.
REQ-020 SHALL produce, for DIV/DIVU, Lo = quotient and Hi = remainder; signed quotient SHALL truncate toward zero and the remainder SHALL take the dividend's sign.
REQ-021 SHALL return, for DIV 0x80000000 / 0xFFFFFFFF, Lo=0x80000000 and Hi=0x00000000 with no flag.
REQ-022 SHALL, on a divide with OperandB=0, skip RUN, go directly IDLE->FIN, pulse Done and DivByZero together, and leave Hi/Lo unchanged.
REQ-023 SHALL update Hi from WriteData on WriteHi=1 and Lo from WriteData on WriteLo=1 only in IDLE; the strobes SHALL be ignored when Busy=1.
REQ-024 SHALL, when Start and WriteHi/WriteLo are both asserted in IDLE, perform both the HI/LO write and the start; the operation's result SHALL overwrite the written value later.
REQ-025 SHALL keep Hi/Lo outputs stable during RUN; internal accumulators SHALL NOT drive Hi/Lo.

Reset
REQ-026 SHALL, on Reset=1, immediately and without a clock edge set state=IDLE, Busy=0, Done=0, DivByZero=0, Hi=0, Lo=0, and clear the counter.
REQ-027 SHALL abort any operation in progress on reset mid-operation, with no Done pulse for the aborted operation.
REQ-028 SHALL accept Start on the first posedge after Reset deasserts.

Verification
REQ-029 SHALL be checked with MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Done at N+33, Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-030 SHALL be checked with MULT 0xFFFFFFFD (-3) x 7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (-21).
REQ-031 SHALL be checked with DIV -7 / 2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); DIVU 100 / 7 -> Lo=14, Hi=2.
REQ-032 SHALL be checked with MTHI 0x12345678 then DIVU 5 / 0 -> DivByZero=1 with Done one cycle after Start; Hi remains 0x12345678.
REQ-033 SHALL be checked with Start asserted again at cycle N+10, plus WriteLo at N+10 -> both ignored; result is from the first operands only.
REQ-034 SHALL be checked with Reset pulsed at cycle N+20 of a MULT -> Busy=0, Hi=Lo=0, no Done; a new Start at the first posedge after deassertion completes normally.
